// File: rtl/worley_noise_pipe.sv
// Worley noise generator: N bouncing feature points, one pixel per clock through a
// four-stage |dx|,|dy| -> d^2 -> F1/F2/argmin -> mode-select pipeline.
module worley_noise_pipe #(
   parameter int unsigned N_POINTS = 4,
   parameter int unsigned COORD_W  = 10,
   parameter int unsigned VEL_W    = 4,
   parameter int unsigned XMAX     = 640,
   parameter int unsigned YMAX     = 480,
   parameter int unsigned SHIFT    = 8,
   parameter int unsigned IDX_W    = (N_POINTS > 1) ? $clog2(N_POINTS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_tick,
   input  logic                     pix_valid,
   input  logic [COORD_W-1:0]       x,
   input  logic [COORD_W-1:0]       y,
   input  logic [1:0]               mode,
   input  logic                     load_en,
   input  logic [IDX_W-1:0]         load_idx,
   input  logic [COORD_W-1:0]       load_x,
   input  logic [COORD_W-1:0]       load_y,
   input  logic signed [VEL_W-1:0]  load_vx,
   input  logic signed [VEL_W-1:0]  load_vy,
   output logic [7:0]               noise,
   output logic                     noise_valid
);
   localparam int unsigned D_W = 2 * COORD_W + 1;
   localparam logic [COORD_W-1:0] X_HI = COORD_W'(XMAX - 1);
   localparam logic [COORD_W-1:0] Y_HI = COORD_W'(YMAX - 1);

   logic [COORD_W-1:0]      px [N_POINTS];
   logic [COORD_W-1:0]      py [N_POINTS];
   logic signed [VEL_W-1:0] vx [N_POINTS];
   logic signed [VEL_W-1:0] vy [N_POINTS];

   logic [COORD_W-1:0] dx_q [N_POINTS];
   logic [COORD_W-1:0] dy_q [N_POINTS];
   logic [D_W-1:0]     d_q  [N_POINTS];
   logic               v1_q, v2_q, v3_q;
   logic [D_W-1:0]     f1_q, f2_q, f1_c, f2_c;
   logic [IDX_W-1:0]   idx1_q, idx1_c;
   logic [1:0]         mode_q;
   logic [7:0]         noise_c;

   // One axis step: reflect off either edge, clamping to the edge on the bounce frame.
   function automatic void bounce(
      input  logic [COORD_W-1:0]      p,
      input  logic signed [VEL_W-1:0] v,
      input  logic [COORD_W-1:0]      hi,
      output logic [COORD_W-1:0]      p_next,
      output logic signed [VEL_W-1:0] v_next
   );
      logic signed [COORD_W:0] n;
      n      = $signed({1'b0, p}) + (COORD_W+1)'(v);
      p_next = n[COORD_W-1:0];
      v_next = v;
      if (n[COORD_W]) begin
         p_next = '0;
         v_next = -v;
      end else if (n[COORD_W-1:0] > hi) begin
         p_next = hi;
         v_next = -v;
      end
   endfunction

   function automatic logic [7:0] sat(input logic [D_W-1:0] v);
      logic [D_W-1:0] s;
      s = v >> SHIFT;
      return (s > D_W'(255)) ? 8'hFF : s[7:0];
   endfunction

   for (genvar g = 0; g < N_POINTS; g++) begin : g_point
      logic [COORD_W-1:0]      nx_c, ny_c;
      logic signed [VEL_W-1:0] nvx_c, nvy_c;

      always_comb begin
         bounce(px[g], vx[g], X_HI, nx_c, nvx_c);
         bounce(py[g], vy[g], Y_HI, ny_c, nvy_c);
      end

      // Point state: a load to this index wins over the frame tick.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            px[g] <= COORD_W'((97 * g + 80) % XMAX);
            py[g] <= COORD_W'((61 * g + 60) % YMAX);
            vx[g] <= (g % 2 == 0) ? VEL_W'(1) : VEL_W'(-1);
            vy[g] <= (g % 3 == 0) ? VEL_W'(1) : VEL_W'(-1);
         end else if (load_en && (load_idx == IDX_W'(g))) begin
            px[g] <= (load_x > X_HI) ? X_HI : load_x;
            py[g] <= (load_y > Y_HI) ? Y_HI : load_y;
            vx[g] <= load_vx;
            vy[g] <= load_vy;
         end else if (frame_tick) begin
            px[g] <= nx_c;
            py[g] <= ny_c;
            vx[g] <= nvx_c;
            vy[g] <= nvy_c;
         end
      end

      // S1 absolute offsets, S2 squared distance.
      always_ff @(posedge clk) begin
         dx_q[g] <= (x >= px[g]) ? (x - px[g]) : (px[g] - x);
         dy_q[g] <= (y >= py[g]) ? (y - py[g]) : (py[g] - y);
         d_q[g]  <= D_W'(dx_q[g]) * D_W'(dx_q[g]) + D_W'(dy_q[g]) * D_W'(dy_q[g]);
      end
   end

   // Smallest and second-smallest distance; strict compare keeps the lowest index on ties.
   always_comb begin
      f1_c   = d_q[0];
      f2_c   = '1;
      idx1_c = '0;
      for (int unsigned i = 1; i < N_POINTS; i++) begin
         if (d_q[IDX_W'(i)] < f1_c) begin
            f2_c   = f1_c;
            f1_c   = d_q[IDX_W'(i)];
            idx1_c = IDX_W'(i);
         end else if (d_q[IDX_W'(i)] < f2_c) begin
            f2_c = d_q[IDX_W'(i)];
         end
      end
   end

   always_ff @(posedge clk) begin
      f1_q   <= f1_c;
      f2_q   <= f2_c;
      idx1_q <= idx1_c;
      mode_q <= mode;
   end

   always_comb begin
      noise_c = '0;
      case (mode_q)
         2'd0:    noise_c = 8'd255 - sat(f1_q);
         2'd1:    noise_c = sat(f1_q);
         2'd2:    noise_c = sat(f2_q - f1_q);
         default: noise_c = 8'(32'(idx1_q) * 37);
      endcase
   end

   // Valid chain and output register; noise holds through bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         noise_valid <= 1'b0;
         noise       <= '0;
      end else begin
         v1_q        <= pix_valid;
         v2_q        <= v1_q;
         v3_q        <= v2_q;
         noise_valid <= v3_q;
         if (v3_q) noise <= noise_c;
      end
   end
endmodule
